// File: rtl/reset_sequencer.sv
// Reset sequencer for the P1V core: merges pushbutton, Prop Plug and PLL lock into p1v_resn.
// Optional RESET_SEQ_CAUSE_EN builds the last-cause and reset-count registers.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 160_000,
  parameter int STRETCH_CYCLES  = 8_000_000
) (
  input  logic       clock,
  input  logic       res,
  input  logic       button_n,
  input  logic       plug_resn,
  input  logic       pll_locked,
  output logic       p1v_resn,
  output logic       running,
  output logic [1:0] cause,
  output logic [7:0] reset_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  // Bit order {lock, plug, button}; lock idles low, the two active-low pins idle high.
  localparam logic [2:0] SYNC_INIT = 3'b011;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STRETCH,
    RUN,
    PLUG
  } state_t;

  wire  [2:0] sync_in;
  wire  [2:0] sync_out;
  logic       button_s;
  logic       plug_s;
  logic       lock_s;

  assign sync_in = {pll_locked, plug_resn, button_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock) begin
        if (res) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= sync_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  assign button_s = sync_out[0];
  assign plug_s   = sync_out[1];
  assign lock_s   = sync_out[2];

  logic            btn_db;
  logic [DB_W-1:0] db_cnt_reg;

  always_ff @(posedge clock) begin
    if (res) begin
      btn_db     <= 1'b1;
      db_cnt_reg <= '0;
    end else if (button_s == btn_db) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      btn_db     <= ~btn_db;
      db_cnt_reg <= '0;
    end else begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  state_t          state_reg;
  state_t          state_next;
  logic            stretch_restart;
  logic [ST_W-1:0] st_cnt_reg;
  logic            p1v_resn_reg;
  logic            running_reg;

  always_comb begin
    state_next      = state_reg;
    stretch_restart = 1'b0;
    case (state_reg)
      HOLD: state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) state_next = STRETCH;
      end
      STRETCH: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (!btn_db || !plug_s) begin
          stretch_restart = 1'b1;
        end else if (st_cnt_reg == ST_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!lock_s)      state_next = WAIT_LOCK;
        else if (!btn_db) state_next = STRETCH;
        else if (!plug_s) state_next = PLUG;
      end
      PLUG: begin
        // Plug release skips the stretch; the button still forces one.
        if (!lock_s)      state_next = WAIT_LOCK;
        else if (!btn_db) state_next = STRETCH;
        else if (plug_s)  state_next = RUN;
      end
      default: state_next = HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (res) begin
      state_reg    <= HOLD;
      st_cnt_reg   <= '0;
      p1v_resn_reg <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_next != state_reg) || stretch_restart) begin
        st_cnt_reg <= '0;
      end else if (state_reg == STRETCH) begin
        st_cnt_reg <= st_cnt_reg + 1'b1;
      end
      p1v_resn_reg <= (state_next == RUN);
      running_reg  <= (state_next == RUN);
    end
  end

  assign p1v_resn = p1v_resn_reg;
  assign running  = running_reg;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_reg;
  logic [7:0] count_reg;
  logic       leave_run;

  assign leave_run = (state_reg == RUN) && (state_next != RUN);

  always_ff @(posedge clock) begin
    if (res) begin
      cause_reg <= 2'd0;
      count_reg <= 8'd0;
    end else if (leave_run) begin
      case (state_next)
        WAIT_LOCK: cause_reg <= 2'd1;
        STRETCH:   cause_reg <= 2'd2;
        default:   cause_reg <= 2'd3;
      endcase
      if (count_reg != 8'hFF) count_reg <= count_reg + 1'b1;
    end
  end

  assign cause       = cause_reg;
  assign reset_count = count_reg;
`else
  assign cause       = 2'd0;
  assign reset_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues cycle-stamped expectations,
// a negedge monitor compares on every output change and on snapshot cycles.
module tb_reset_sequencer;

`ifdef RESET_SEQ_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic       button_n;
  logic       plug_resn;
  logic       pll_locked;
  logic       p1v_resn;
  logic       running;
  logic [1:0] cause;
  logic [7:0] reset_count;

  typedef struct {
    int         cyc;
    logic       resn;
    logic [1:0] cause;
    logic [7:0] count;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;
  logic prev_resn;
  logic prev_run;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (16)
  ) dut (
    .clock      (clk),
    .res        (res),
    .button_n   (button_n),
    .plug_resn  (plug_resn),
    .pll_locked (pll_locked),
    .p1v_resn   (p1v_resn),
    .running    (running),
    .cause      (cause),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic r, input logic [1:0] ca,
                               input logic [7:0] co, input string tag);
    exp_t e;
    e.cyc   = c;
    e.resn  = r;
    e.cause = CAUSE_EN ? ca : 2'd0;
    e.count = CAUSE_EN ? co : 8'd0;
    e.tag   = tag;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sole owner of the counters and of the summary line.
  always @(negedge clk) begin
    exp_t e;
    bit   changed;
    if (done || cyc > 5000) begin
      if (!done) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout: cycle %0d reached, stimulus never finished", cyc);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: expected event at cycle %0d never checked", e.tag, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (cyc >= 2) begin
      changed = (p1v_resn !== prev_resn) || (running !== prev_run);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: cycle %0d passed without check (now %0d)", e.tag, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if (p1v_resn !== e.resn || running !== e.resn || cause !== e.cause ||
            reset_count !== e.count) begin
          miscompares++;
          $display("FAIL %s @%0d: got resn=%0b running=%0b cause=%0d count=%0d, want resn=%0b running=%0b cause=%0d count=%0d",
                   e.tag, cyc, p1v_resn, running, cause, reset_count,
                   e.resn, e.resn, e.cause, e.count);
        end
      end else if (changed) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_change @%0d: got resn=%0b running=%0b, want resn=%0b running=%0b",
                 cyc, p1v_resn, running, prev_resn, prev_run);
      end
    end
    prev_resn = p1v_resn;
    prev_run  = running;
  end

  initial begin
    int c;
    int n;
    res        = 1'b1;
    button_n   = 1'b1;
    plug_resn  = 1'b1;
    pll_locked = 1'b1;

    // 1: power-up release with lock already high
    tick(2);
    push(cyc + 1, 1'b0, 2'd0, 8'd0, "reset_state");
    res = 1'b0;
    c   = cyc;
    push(c + 18, 1'b0, 2'd0, 8'd0, "release_still_low");
    push(c + 19, 1'b1, 2'd0, 8'd0, "release_run");
    tick(25);

    // 2a: short press is filtered
    button_n = 1'b0;
    c        = cyc;
    push(c + 10, 1'b1, 2'd0, 8'd0, "short_press_ignored");
    tick(3);
    button_n = 1'b1;
    tick(12);

    // 2b: long press, stretch counted from debounced release
    button_n = 1'b0;
    c        = cyc;
    push(c + 7, 1'b0, 2'd2, 8'd1, "button_fall");
    tick(20);
    button_n = 1'b1;
    c        = cyc;
    push(c + 22, 1'b1, 2'd2, 8'd1, "button_release_run");
    tick(26);

    // 3: plug pulse, no stretch
    plug_resn = 1'b0;
    c         = cyc;
    push(c + 3, 1'b0, 2'd3, 8'd2, "plug_fall");
    tick(5);
    plug_resn = 1'b1;
    push(cyc + 3, 1'b1, 2'd3, 8'd2, "plug_rise");
    tick(8);

    // 4: lock loss, then lock drop at stretch count 10 forces a full new stretch
    pll_locked = 1'b0;
    c          = cyc;
    push(c + 3, 1'b0, 2'd1, 8'd3, "lock_loss");
    tick(5);
    pll_locked = 1'b1;
    tick(11);
    pll_locked = 1'b0;
    tick(5);
    pll_locked = 1'b1;
    c          = cyc;
    push(c + 18, 1'b0, 2'd1, 8'd3, "restretch_min_low");
    push(c + 19, 1'b1, 2'd1, 8'd3, "restretch_run");
    tick(24);

    // 5: simultaneous plug and button: plug wins, then stretch
    button_n  = 1'b0;
    plug_resn = 1'b0;
    c         = cyc;
    push(c + 3, 1'b0, 2'd3, 8'd4, "dual_plug_first");
    push(c + 8, 1'b0, 2'd3, 8'd4, "dual_in_stretch");
    tick(10);
    button_n  = 1'b1;
    plug_resn = 1'b1;
    c         = cyc;
    push(c + 22, 1'b1, 2'd3, 8'd4, "dual_release_run");
    tick(26);

    // 5b: 260 plug pulses saturate reset_count
    for (int i = 0; i < 260; i++) begin
      plug_resn = 1'b0;
      c         = cyc;
      tick(1);
      plug_resn = 1'b1;
      n         = (5 + i > 255) ? 255 : 5 + i;
      push(c + 3, 1'b0, 2'd3, 8'(n), "pulse_fall");
      push(c + 4, 1'b1, 2'd3, 8'(n), "pulse_rise");
      tick(5);
    end

    // 6: res asserted mid-stretch clears everything on the next edge
    button_n = 1'b0;
    c        = cyc;
    push(c + 7, 1'b0, 2'd2, 8'd255, "press_saturated");
    tick(10);
    res      = 1'b1;
    button_n = 1'b1;
    push(cyc + 1, 1'b0, 2'd0, 8'd0, "res_mid_stretch");
    tick(2);
    res = 1'b0;
    c   = cyc;
    push(c + 19, 1'b1, 2'd0, 8'd0, "rerelease_run");
    tick(24);

    done = 1'b1;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer for the P1V core on the DE0-Nano board. It merges three reset sources into the single active-low core reset `p1v_resn`:
- the board pushbutton, which is debounced and stretched;
- the Prop Plug reset pin, which is synchronized and passed through unstretched;
- PLL lock.

It sits between the board top level and `p1v`, replacing the ad-hoc `!res & pin_resn` gate. It optionally records the cause of the last reset for LED or debug display.

## Interface
- `DEBOUNCE_CYCLES`, default 160_000: consecutive stable cycles required to change debounced button state (1 ms at 160 MHz); must be ≥1.
- `STRETCH_CYCLES`, default 8_000_000: minimum `p1v_resn` low time after button or lock release (50 ms at 160 MHz); must be ≥1.
- `clock`  in  1  system clock (clock_160).
- `res`  in  1  synchronous, active-high reset.
- `button_n`  in  1  raw pushbutton, low = pressed; asynchronous.
- `plug_resn`  in  1  Prop Plug reset pin, low = reset; asynchronous.
- `pll_locked`  in  1  PLL lock; asynchronous.
- `p1v_resn`  out  1  registered core reset, low = reset. Reset value 0.
- `running`  out  1  high when state = RUN. Reset value 0.
- `cause`  out  2  last reset cause: 0 = `res`, 1 = lock loss, 2 = button, 3 = plug. Reset value 0.
- `reset_count`  out  8  saturating count of resets entered from RUN. Reset value 0.

## Operation
- **Synchronizers.** Each of `button_n`, `plug_resn` and `pll_locked` passes through a 2-flop synchronizer.
  - Reset values: `button_s` = 1, `plug_s` = 1, `lock_s` = 0.
- **Debouncer.**
  - `btn_db` has a reset value of 1 (released).
  - A counter clears whenever `button_s` == `btn_db`.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`−1, `btn_db` toggles and the counter clears.
- **Stretch counter.**
  - Width: `$clog2(STRETCH_CYCLES+1)`.
  - Clears on every state entry and on every restart.
  - Increments only in STRETCH.
- **States.** Registered state; `res` forces HOLD. Transition priority is lock loss > button pressed (`btn_db`=0) > plug low (`plug_s`=0).
  - HOLD: `p1v_resn`=0. Next cycle goes to WAIT_LOCK.
  - WAIT_LOCK: `p1v_resn`=0. Goes to STRETCH when `lock_s`=1.
  - STRETCH: `p1v_resn`=0.
    - `lock_s`=0 → WAIT_LOCK.
    - `btn_db`=0 or `plug_s`=0 → counter restarts at 0 and state stays in STRETCH.
    - Counter == `STRETCH_CYCLES`−1 with no source active → RUN.
  - RUN: `p1v_resn`=1.
    - `lock_s`=0 → WAIT_LOCK, `cause`=1.
    - `btn_db`=0 → STRETCH, `cause`=2.
    - `plug_s`=0 → PLUG, `cause`=3.
    - Each exit from RUN increments `reset_count`, saturating at 255.
  - PLUG: `p1v_resn`=0.
    - `lock_s`=0 → WAIT_LOCK.
    - `btn_db`=0 → STRETCH. `cause` is not updated.
    - `plug_s`=1 → RUN, with no stretch.
- `res` mid-operation: all state, counters, `cause` and `reset_count` return to their reset values on the same edge.
- `p1v_resn` and `running` are registered from next-state, so they change on the same edge as the state.

## Timing
- Plug fall or rise to `p1v_resn` change: 3 cycles (2 synchronizer + 1 state).
- Button press to `p1v_resn` low: 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- Lock loss to `p1v_resn` low: 3 cycles.
- After `res` deasserts with lock already high:
  - edge 1 → WAIT_LOCK;
  - edge 2 → `lock_s`=1;
  - edge 3 → STRETCH;
  - `p1v_resn` rises at edge 3 + `STRETCH_CYCLES`.
- Minimum `p1v_resn` low after a button or lock release: exactly `STRETCH_CYCLES` cycles in STRETCH.

## Configuration
- `RESET_SEQ_CAUSE_EN`
  - **Defined:** the `cause` and `reset_count` registers are built as described in Operation.
  - **Undefined:** no cause or count flops are built; `cause` and `reset_count` are tied to 0. Sequencing and `p1v_resn` behaviour are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `STRETCH_CYCLES`=16, `RESET_SEQ_CAUSE_EN` defined.
1. `res`=1 for 2 cycles with `pll_locked`=1, then release → `p1v_resn` and `running` rise at edge 19 after release; `cause`=0, `reset_count`=0.
2. In RUN, `button_n` low 3 cycles → no change. `button_n` low 20 cycles → `p1v_resn` low 7 cycles after the fall, high 16 cycles after `btn_db` returns to 1; `cause`=2, `reset_count`=1.
3. In RUN, `plug_resn` low 5 cycles → `p1v_resn` low 3 cycles after the fall, high 3 cycles after the rise with no stretch; `cause`=3.
4. `pll_locked` drops at STRETCH counter=10 → WAIT_LOCK. After lock returns, a full 16-cycle stretch is required before RUN.
5. `button_n` and `plug_resn` fall together in RUN → PLUG is entered first (plug reaches its state 7−3 cycles sooner), then STRETCH once the button debounces; `cause`=3 and `reset_count` +1 only. Repeat 260 plug pulses → `reset_count` holds 255.
6. Assert `res` mid-STRETCH → next edge: state HOLD, `p1v_resn`=0, `cause`=0, `reset_count`=0.
